stall_buf_ctrl: RTL and testbench

- Sequencing controller for one pipeline-stage 2-slot stall buffer (slot 0 = output/regular slot, slot 1 = stall slot).
- Converts an upstream valid/ready and downstream valid/ready handshake, plus a pipeline flush request, into the buffer's enq/deq/flush strobes.
- Tracks occupancy in its own FSM and cross-checks it against the buffer's empty/full flags.
- Counts upstream stall cycles for performance monitoring. One instance sits beside each stage buffer.

---
 rtl/stall_pkg.sv | 24 ++
 rtl/stall_buf_ctrl_sat_counter.sv | 38 +++
 rtl/stall_buf_ctrl.sv | 158 +++++++++++++++
 tb/tb_stall_buf_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/stall_pkg.sv
// -----------------------------------------------------------------------------
// stall_pkg
// Shared types and constants for the stall-buffer sequencing controller and
// its helpers.
//   state_t   : controller FSM state (2-bit encoding)
//   OCC_*     : occupancy values reported on the occupancy port
//   FT_W      : width of the post-flush hold timer
// -----------------------------------------------------------------------------
package stall_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  localparam int FT_W = 4;

endpackage

// File: rtl/stall_buf_ctrl_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with synchronous clear. Clear wins over increment;
// the count sticks at all-ones instead of wrapping.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   i_inc      : count one event this cycle
//   i_clr      : synchronous clear (priority over i_inc)
//   o_cnt      : current count
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_at_max;

  assign w_at_max = &r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !w_at_max) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/stall_buf_ctrl.sv
// -----------------------------------------------------------------------------
// stall_buf_ctrl
// Sequencing controller for a 2-slot stall buffer (slot 0 = output slot,
// slot 1 = stall slot). Turns upstream/downstream valid/ready plus a pipeline
// flush into enq/deq/flush strobes, tracks occupancy, cross-checks it against
// the buffer's empty/full flags and counts upstream stall cycles.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   in_valid / in_ready   : upstream handshake
//   out_valid / out_ready : downstream handshake (slot 0 contents)
//   flush_req             : pipeline flush request
//   buf_enq/deq/flush     : strobes to the buffer
//   buf_empty / buf_full  : buffer status flags
//   occupancy             : entries held (0..2), 0 while flushing
//   stall_cycles          : saturating upstream stall count
//   clr_stats             : synchronous clear of stall_cycles
//   err                   : sticky occupancy/flag mismatch
//
// state    | meaning
// ---------+------------------------------------------------
// ST_EMPTY | buffer empty, accepting
// ST_ONE   | slot 0 valid, accepting unless releasing
// ST_TWO   | both slots valid, upstream stalled
// ST_FLUSH | flush in progress, timer counting down to EMPTY
// -----------------------------------------------------------------------------
module stall_buf_ctrl
  import stall_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             flush_req,
  output logic             buf_enq,
  output logic             buf_deq,
  output logic             buf_flush,
  input  logic             buf_empty,
  input  logic             buf_full,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cycles,
  input  logic             clr_stats,
  output logic             err
);

  localparam logic [FT_W-1:0] FT_LOAD = FT_W'(FLUSH_CYCLES - 1);

  state_t          r_state;
  logic [1:0]      r_occ;
  logic [FT_W-1:0] r_timer;
  logic            r_post_flush;
  logic            r_err;

  logic w_rel;
  logic w_acc;
  logic w_chk_en;
  logic w_mismatch;
  logic w_stall;

  assign out_valid = (r_state == ST_ONE) || (r_state == ST_TWO);
  assign w_rel     = out_valid && out_ready;

  // A release beat blocks acceptance so only one buffer operation happens
  // per cycle. While reset is held the handshake shows its idle values and
  // no strobe reaches the buffer.
  assign in_ready  = reset ||
                     (((r_state == ST_EMPTY) || (r_state == ST_ONE)) &&
                      !w_rel && !flush_req);
  assign w_acc     = in_valid && in_ready && !reset;

  assign buf_enq   = w_acc;
  assign buf_deq   = w_rel && !flush_req && !reset;
  assign buf_flush = flush_req && !reset;

  // Flags are not trusted while flushing or on the cycle right after, when
  // the buffer may still be settling from its own flush.
  assign w_chk_en   = (r_state != ST_FLUSH) && !r_post_flush;
  assign w_mismatch = (buf_empty != (r_state == ST_EMPTY)) ||
                      (buf_full  != (r_state == ST_TWO));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_EMPTY;
      r_occ        <= OCC_EMPTY;
      r_timer      <= '0;
      r_post_flush <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_post_flush <= (r_state == ST_FLUSH);
      if (w_chk_en && w_mismatch) begin
        r_err <= 1'b1;
      end

      if (flush_req) begin
        r_state <= ST_FLUSH;
        r_occ   <= OCC_EMPTY;
        r_timer <= FT_LOAD;
      end else begin
        case (r_state)
          ST_EMPTY: begin
            if (w_acc) begin
              r_state <= ST_ONE;
              r_occ   <= OCC_ONE;
            end
          end
          ST_ONE: begin
            if (w_acc) begin
              r_state <= ST_TWO;
              r_occ   <= OCC_FULL;
            end else if (w_rel) begin
              r_state <= ST_EMPTY;
              r_occ   <= OCC_EMPTY;
            end
          end
          ST_TWO: begin
            if (w_rel) begin
              r_state <= ST_ONE;
              r_occ   <= OCC_ONE;
            end
          end
          ST_FLUSH: begin
            if (r_timer == '0) begin
              r_state <= ST_EMPTY;
              r_occ   <= OCC_EMPTY;
            end else begin
              r_timer <= r_timer - 1'b1;
            end
          end
          default: begin
            r_state <= ST_EMPTY;
            r_occ   <= OCC_EMPTY;
          end
        endcase
      end
    end
  end

  assign occupancy = r_occ;
  assign err       = r_err;

  // Upstream stall: data offered but not taken, flush cycles included.
  assign w_stall = in_valid && !in_ready;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .i_inc (w_stall),
    .i_clr (clr_stats),
    .o_cnt (stall_cycles)
  );

endmodule

// File: tb/tb_stall_buf_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stall_buf_ctrl
// Directed walk through the main scenarios followed by randomized traffic.
// A behavioural model (occupancy count, flush countdown, stall count, sticky
// error) predicts every output each cycle; a small buffer model drives the
// empty/full flags, with optional fault injection on those flags.
// -----------------------------------------------------------------------------
module tb_stall_buf_ctrl;

  localparam int CNT_W        = 4;
  localparam int FLUSH_CYCLES = 3;
  localparam int SAT_MAX      = (1 << CNT_W) - 1;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic             flush_req;
  logic             buf_enq;
  logic             buf_deq;
  logic             buf_flush;
  logic             buf_empty;
  logic             buf_full;
  logic [1:0]       occupancy;
  logic [CNT_W-1:0] stall_cycles;
  logic             clr_stats;
  logic             err;

  stall_buf_ctrl #(
    .CNT_W        (CNT_W),
    .FLUSH_CYCLES (FLUSH_CYCLES)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .flush_req    (flush_req),
    .buf_enq      (buf_enq),
    .buf_deq      (buf_deq),
    .buf_flush    (buf_flush),
    .buf_empty    (buf_empty),
    .buf_full     (buf_full),
    .occupancy    (occupancy),
    .stall_cycles (stall_cycles),
    .clr_stats    (clr_stats),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // buffer model: entry count reacting to the strobes, flags optionally forced
  int   b_cnt;
  int   b_nxt;
  logic inj_en, inj_empty, inj_full;

  assign buf_empty = inj_en ? inj_empty : (b_cnt == 0);
  assign buf_full  = inj_en ? inj_full  : (b_cnt == 2);

  always @(posedge clk or posedge reset) begin
    if (reset) b_cnt <= 0;
    else       b_cnt <= b_nxt;
  end

  // controller model
  int m_cnt, m_left, m_stall;
  bit m_fl, m_skip, m_err;
  bit e_ov, e_rel, e_ir, e_acc;

  always @(negedge clk) begin
    if (reset) begin
      m_cnt = 0; m_left = 0; m_stall = 0;
      m_fl = 0; m_skip = 0; m_err = 0;
      b_nxt = 0;
      chk("rst_occupancy", occupancy, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_strobes", {buf_enq, buf_deq, buf_flush}, 0);
      chk("rst_stall", stall_cycles, 0);
      chk("rst_err", err, 0);
    end else begin
      e_ov  = !m_fl && (m_cnt > 0);
      e_rel = e_ov && out_ready;
      e_ir  = !m_fl && (m_cnt < 2) && !e_rel && !flush_req;
      e_acc = in_valid && e_ir;

      chk("out_valid", out_valid, e_ov);
      chk("in_ready", in_ready, e_ir);
      chk("buf_enq", buf_enq, e_acc);
      chk("buf_deq", buf_deq, e_rel && !flush_req);
      chk("buf_flush", buf_flush, flush_req);
      chk("occupancy", occupancy, m_fl ? 0 : m_cnt);
      chk("stall_cycles", stall_cycles, m_stall);
      chk("err", err, m_err);

      if (buf_flush)    b_nxt = 0;
      else if (buf_enq) b_nxt = (b_cnt < 2) ? b_cnt + 1 : 2;
      else if (buf_deq) b_nxt = (b_cnt > 0) ? b_cnt - 1 : 0;
      else              b_nxt = b_cnt;

      if (!m_fl && !m_skip &&
          ((buf_empty != (m_cnt == 0)) || (buf_full != (m_cnt == 2))))
        m_err = 1;
      m_skip = m_fl;

      if (clr_stats) m_stall = 0;
      else if (in_valid && !e_ir && m_stall < SAT_MAX) m_stall++;

      if (flush_req) begin
        m_fl = 1; m_left = FLUSH_CYCLES; m_cnt = 0;
      end else if (m_fl) begin
        m_left--;
        if (m_left == 0) m_fl = 0;
      end else begin
        m_cnt = m_cnt + (e_acc ? 1 : 0) - (e_rel ? 1 : 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1; in_valid = 0; out_ready = 0; flush_req = 0; clr_stats = 0;
    inj_en = 0; inj_empty = 0; inj_full = 0; b_nxt = 0;
    tick(); tick();
    reset = 0;
    #1;
    chk("lit_reset_occ", occupancy, 0);
    chk("lit_reset_in_ready", in_ready, 1);

    // two enqueues with downstream stalled, then a stall cycle
    in_valid = 1; out_ready = 0; #1;
    chk("lit_enq1", buf_enq, 1);
    tick(); chk("lit_occ1", occupancy, 1);
    chk("lit_enq2", buf_enq, 1);
    tick(); chk("lit_occ2", occupancy, 2);
    chk("lit_full_in_ready", in_ready, 0);
    tick(); chk("lit_stall1", stall_cycles, 1);

    // drain to one, then simultaneous offer and release
    in_valid = 0; out_ready = 1; tick();
    chk("lit_drain_occ", occupancy, 1);
    in_valid = 1; #1;
    chk("lit_rel_deq", buf_deq, 1);
    chk("lit_rel_enq", buf_enq, 0);
    chk("lit_rel_in_ready", in_ready, 0);
    tick(); chk("lit_rel_occ0", occupancy, 0);
    tick(); chk("lit_reaccept_occ1", occupancy, 1);
    out_ready = 0; tick();
    chk("lit_refill_occ2", occupancy, 2);

    // flush while full with downstream ready
    in_valid = 0; out_ready = 1; flush_req = 1; #1;
    chk("lit_flush_strobe", buf_flush, 1);
    chk("lit_flush_no_deq", buf_deq, 0);
    tick(); flush_req = 0; #1;
    for (int i = 0; i < FLUSH_CYCLES; i++) begin
      chk("lit_flushing_in_ready", in_ready, 0);
      chk("lit_flushing_out_valid", out_valid, 0);
      tick();
    end
    chk("lit_post_flush_in_ready", in_ready, 1);

    // saturation and clear
    in_valid = 1; out_ready = 0;
    repeat (22) tick();
    chk("lit_sat_occ", occupancy, 2);
    chk("lit_sat_stall", stall_cycles, SAT_MAX);
    in_valid = 0; clr_stats = 1; tick(); clr_stats = 0;
    chk("lit_clr_stall", stall_cycles, 0);

    // flag mismatch in ONE, sticky through traffic, cleared by reset
    out_ready = 1; tick(); out_ready = 0;
    chk("lit_one_occ", occupancy, 1);
    inj_en = 1; inj_full = 1; inj_empty = 0; tick(); inj_en = 0;
    chk("lit_err_set", err, 1);
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'($urandom_range(0, 1)); out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    chk("lit_err_sticky", err, 1);
    in_valid = 1; out_ready = 0; tick(); tick();
    chk("lit_midstream_busy", int'(occupancy != 0), 1);
    reset = 1; #1;
    chk("lit_async_occ", occupancy, 0);
    chk("lit_async_err", err, 0);
    chk("lit_async_no_flush", buf_flush, 0);
    tick(); reset = 0;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid  = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 2) != 0);
      flush_req = 1'($urandom_range(0, 29) == 0);
      clr_stats = 1'($urandom_range(0, 99) == 0);
      inj_en    = 1'($urandom_range(0, 199) == 0);
      inj_empty = 1'($urandom_range(0, 1));
      inj_full  = 1'($urandom_range(0, 1));
      reset     = 1'($urandom_range(0, 499) == 0);
      tick();
    end
    reset = 0; inj_en = 0; flush_req = 0;
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
